// File: rtl/hilo_div_pkg.sv
// Shared definitions for the HI/LO divide unit: FSM state encodings and
// handshake constants used by the EX stage and the divider.
package hilo_div_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BYZERO = 2'b01,
    ON     = 2'b10,
    END    = 2'b11
  } state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/hilo_div.sv
// Iterative HI/LO divider: restoring divide, one quotient bit per cycle.
// result_o = {remainder, quotient} for divide, {product hi, product lo} for
// multiply. Optional multiply path enabled by defining HILO_DIV_MUL_EN;
// without it mode_i is ignored and every operation is a divide.
module hilo_div
  import hilo_div_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic           annul_i,
  input  logic           signed_i,
  input  logic           mode_i,
  input  logic [W-1:0]   opdata1_i,
  input  logic [W-1:0]   opdata2_i,
  output logic [2*W-1:0] result_o,
  output logic           ready_o,
  output logic           busy_o
);

  localparam int unsigned CW = $clog2(W) + 1;
  localparam int unsigned W1 = W + 1;
  localparam int unsigned RW = 2 * W;
  localparam int unsigned WW = 2 * W + 1;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [WW-1:0]  work_q, work_d;
  logic [W-1:0]   opnd_q, opnd_d;
  logic           mul_q, mul_d;
  logic           neg_q, neg_d;
  logic           neg_rem_q, neg_rem_d;
  logic [RW-1:0]  result_q, result_d;
  logic           ready_q, ready_d;
  logic           busy_c;

  logic           mul_sel_c;
  logic [W-1:0]   abs1_c, abs2_c;
  logic [W:0]     div_hi_c, div_diff_c, mul_sum_c;
  logic [WW-1:0]  div_step_c, mul_step_c;
  logic [W-1:0]   quot_c, rem_c;
  logic [RW-1:0]  prod_c, final_c;

`ifdef HILO_DIV_MUL_EN
  assign mul_sel_c = mode_i;
`else
  logic unused_mode_c;
  assign mul_sel_c     = 1'b0;
  assign unused_mode_c = mode_i;
`endif

  // Operand magnitudes for signed requests; the most negative value maps to itself as unsigned.
  always_comb begin
    abs1_c = (signed_i && opdata1_i[W-1]) ? W'(0) - opdata1_i : opdata1_i;
    abs2_c = (signed_i && opdata2_i[W-1]) ? W'(0) - opdata2_i : opdata2_i;
  end

  // One iteration of restoring divide or shift-add multiply, plus final sign correction.
  always_comb begin
    div_hi_c   = work_q[2*W-1:W-1];
    div_diff_c = div_hi_c - {1'b0, opnd_q};
    if (div_diff_c[W]) begin
      div_step_c = {work_q[WW-2:0], 1'b0};
    end else begin
      div_step_c = {div_diff_c, work_q[W-2:0], 1'b1};
    end
    mul_sum_c  = work_q[0] ? work_q[WW-1:W] + {1'b0, opnd_q} : work_q[WW-1:W];
    mul_step_c = {1'b0, mul_sum_c, work_q[W-1:1]};
    quot_c     = neg_q     ? W'(0) - work_q[W-1:0]     : work_q[W-1:0];
    rem_c      = neg_rem_q ? W'(0) - work_q[2*W-1:W]   : work_q[2*W-1:W];
    prod_c     = neg_q     ? RW'(0) - work_q[2*W-1:0]  : work_q[2*W-1:0];
    final_c    = mul_q ? prod_c : {rem_c, quot_c};
  end

  // Next state, datapath next values and the stall request.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    opnd_d    = opnd_q;
    mul_d     = mul_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    result_d  = '0;
    busy_c    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i == DIV_START && !annul_i) begin
          busy_c    = 1'b1;
          mul_d     = mul_sel_c;
          neg_d     = signed_i & (opdata1_i[W-1] ^ opdata2_i[W-1]);
          neg_rem_d = signed_i & opdata1_i[W-1];
          cnt_d     = '0;
          if (mul_sel_c) begin
            opnd_d = abs1_c;
            work_d = {W1'(0), abs2_c};
          end else begin
            opnd_d = abs2_c;
            work_d = {W1'(0), abs1_c};
          end
          if (!mul_sel_c && opdata2_i == '0) begin
            state_d = BYZERO;
          end else begin
            state_d = ON;
          end
        end
      end
      BYZERO: begin
        busy_c = 1'b1;
        if (annul_i) begin
          state_d = IDLE;
        end else begin
          state_d = END;
        end
      end
      ON: begin
        busy_c = 1'b1;
        if (annul_i) begin
          state_d = IDLE;
        end else if (cnt_q == CW'(W)) begin
          state_d  = END;
          result_d = final_c;
        end else begin
          work_d = mul_q ? mul_step_c : div_step_c;
          cnt_d  = cnt_q + CW'(1);
        end
      end
      END: begin
        if (!annul_i && start_i == DIV_START) begin
          result_d = result_q;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == END) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      work_q    <= '0;
      opnd_q    <= '0;
      mul_q     <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= DIV_RESULT_NOT_READY;
    end else begin
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      opnd_q    <= opnd_d;
      mul_q     <= mul_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = busy_c;

endmodule

// File: tb/tb_hilo_div.sv
// Directed bench for hilo_div (W=32): vector table plus hand-written
// sequences for annul, reset, hold-in-END and start gating.
module tb_hilo_div;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic          annul_i;
  logic          signed_i;
  logic          mode_i;
  logic [W-1:0]  opdata1_i;
  logic [W-1:0]  opdata2_i;
  logic [2*W-1:0] result_o;
  logic          ready_o;
  logic          busy_o;

  int checks = 0;
  int errors = 0;

  hilo_div #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .annul_i   (annul_i),
    .signed_i  (signed_i),
    .mode_i    (mode_i),
    .opdata1_i (opdata1_i),
    .opdata2_i (opdata2_i),
    .result_o  (result_o),
    .ready_o   (ready_o),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sg;
    logic        md;
    logic [63:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Start an operation from IDLE and wait (bounded) for ready_o; operands are scrambled after the start sample.
  task automatic run_to_ready(input string name, input logic [31:0] a, input logic [31:0] b,
                              input logic sg, input logic md, output int n);
    opdata1_i = a;
    opdata2_i = b;
    signed_i  = sg;
    mode_i    = md;
    start_i   = 1'b1;
    #1;
    check({name, " busy at start"}, 64'(busy_o), 64'd1);
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        check({name, " busy in flight"}, 64'(busy_o), 64'd1);
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        signed_i  = ~sg;
        mode_i    = ~md;
      end
      if (ready_o) break;
    end
  endtask

  // Full transaction: latency, result, END behaviour for hold cycles, then return to IDLE.
  task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic sg, input logic md, input logic [63:0] exp,
                       input int exp_lat, input int hold);
    int n;
    run_to_ready(name, a, b, sg, md, n);
    check({name, " latency"}, 64'(n), 64'(exp_lat));
    check({name, " result"}, result_o, exp);
    check({name, " busy in END"}, 64'(busy_o), 64'd0);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s hold%0d ready", name, k), 64'(ready_o), 64'd1);
      check($sformatf("%s hold%0d result", name, k), result_o, exp);
    end
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check({name, " ready after release"}, 64'(ready_o), 64'd0);
    check({name, " result after release"}, result_o, 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    vecs.push_back('{32'd100,        32'd7,          1'b0, 1'b0, {32'd2, 32'd14}, 34});
    vecs.push_back('{32'hFFFFFFF9,   32'd2,          1'b1, 1'b0, {32'hFFFFFFFF, 32'hFFFFFFFD}, 34});
    vecs.push_back('{32'd5,          32'd0,          1'b0, 1'b0, 64'd0, 2});
    vecs.push_back('{32'd5,          32'd0,          1'b1, 1'b0, 64'd0, 2});
    vecs.push_back('{32'h80000000,   32'hFFFFFFFF,   1'b1, 1'b0, {32'd0, 32'h80000000}, 34});
    vecs.push_back('{32'd7,          32'hFFFFFFFE,   1'b1, 1'b0, {32'd1, 32'hFFFFFFFD}, 34});
    vecs.push_back('{32'hFFFFFFF9,   32'hFFFFFFFE,   1'b1, 1'b0, {32'hFFFFFFFF, 32'd3}, 34});
    vecs.push_back('{32'hFFFFFFF9,   32'd2,          1'b0, 1'b0, {32'd1, 32'h7FFFFFFC}, 34});
    vecs.push_back('{32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 1'b0, {32'd0, 32'd1}, 34});
    vecs.push_back('{32'd3,          32'd10,         1'b0, 1'b0, {32'd3, 32'd0}, 34});
`ifdef HILO_DIV_MUL_EN
    vecs.push_back('{32'hFFFFFFFF,   32'd2,          1'b0, 1'b1, {32'h00000001, 32'hFFFFFFFE}, 34});
    vecs.push_back('{32'hFFFFFFFD,   32'd4,          1'b1, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFF4}, 34});
    vecs.push_back('{32'd1234,       32'd0,          1'b0, 1'b1, 64'd0, 34});
`else
    vecs.push_back('{32'hFFFFFFFF,   32'd2,          1'b0, 1'b1, {32'd1, 32'h7FFFFFFF}, 34});
    vecs.push_back('{32'hFFFFFFFD,   32'd4,          1'b1, 1'b1, {32'hFFFFFFFD, 32'd0}, 34});
    vecs.push_back('{32'd1234,       32'd0,          1'b0, 1'b1, 64'd0, 2});
`endif

    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_i = 1'b0; mode_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset ready", 64'(ready_o), 64'd0);
    check("reset busy", 64'(busy_o), 64'd0);
    check("reset result", result_o, 64'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sg, vecs[i].md,
            vecs[i].res, vecs[i].lat, 0);
    end

    // Hold start_i for 5 cycles in END.
    do_op("hold", 32'd100, 32'd7, 1'b0, 1'b0, {32'd2, 32'd14}, 34, 5);

    // annul_i in IDLE blocks a start.
    opdata1_i = 32'd9; opdata2_i = 32'd3; signed_i = 1'b0; mode_i = 1'b0;
    annul_i = 1'b1; start_i = 1'b1;
    #1;
    check("annul idle busy", 64'(busy_o), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("annul idle busy later", 64'(busy_o), 64'd0);
    check("annul idle ready", 64'(ready_o), 64'd0);
    annul_i = 1'b0; start_i = 1'b0;
    @(posedge clk);
    #1;

    // annul_i at step 10 of ON, then an immediate new start.
    opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    check("annul on ready before", 64'(ready_o), 64'd0);
    annul_i = 1'b1; start_i = 1'b0;
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    check("annul on busy", 64'(busy_o), 64'd0);
    check("annul on ready", 64'(ready_o), 64'd0);
    do_op("after annul", 32'd9, 32'd3, 1'b0, 1'b0, {32'd0, 32'd3}, 34, 0);

    // annul_i in BYZERO.
    opdata1_i = 32'd5; opdata2_i = 32'd0; start_i = 1'b1;
    @(posedge clk);
    #1;
    annul_i = 1'b1; start_i = 1'b0;
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    check("annul byzero ready", 64'(ready_o), 64'd0);
    @(posedge clk);
    #1;
    check("annul byzero ready later", 64'(ready_o), 64'd0);

    // annul_i in END with start_i still high.
    run_to_ready("annul end", 32'd20, 32'd6, 1'b0, 1'b0, n);
    check("annul end latency", 64'(n), 64'd34);
    check("annul end result", result_o, {32'd2, 32'd3});
    annul_i = 1'b1;
    @(posedge clk);
    #1;
    check("annul end ready", 64'(ready_o), 64'd0);
    check("annul end result cleared", result_o, 64'd0);
    check("annul end busy", 64'(busy_o), 64'd0);
    annul_i = 1'b0; start_i = 1'b0;
    @(posedge clk);
    #1;

    // rst mid-ON takes priority over a held start_i.
    opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; start_i = 1'b0;
    #1;
    check("rst on busy", 64'(busy_o), 64'd0);
    check("rst on ready", 64'(ready_o), 64'd0);
    @(posedge clk);
    #1;

    // rst in END clears the result.
    run_to_ready("rst end", 32'd50, 32'd8, 1'b0, 1'b0, n);
    check("rst end result", result_o, {32'd2, 32'd6});
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; start_i = 1'b0;
    check("rst end ready", 64'(ready_o), 64'd0);
    check("rst end result cleared", result_o, 64'd0);
    @(posedge clk);
    #1;

    do_op("post rst", 32'd9, 32'd3, 1'b1, 1'b0, {32'd0, 32'd3}, 34, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_div.md
HILO_DIV -- requirements
Module: hilo_div

Interface
REQ-001 SHALL have parameter W, default 32, giving the operand width; result width is 2*W.
REQ-002 SHALL have clk  input  1  rising-edge clock.
REQ-003 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have start_i  input  1  request an operation; held high by the EX stage until ready_o is seen.
REQ-005 SHALL have annul_i  input  1  cancel the operation in flight (pipeline flush).
REQ-006 SHALL have signed_i  input  1  1 = signed operands, 0 = unsigned.
REQ-007 SHALL have mode_i  input  1  0 = divide, 1 = multiply (multiply only under REQ-024).
REQ-008 SHALL have opdata1_i  input  W  dividend or multiplicand.
REQ-009 SHALL have opdata2_i  input  W  divisor or multiplier.
REQ-010 SHALL have result_o  output  2W  divide: {remainder, quotient}; multiply: {product high, product low}; maps to {HI, LO}.
REQ-011 SHALL have ready_o  output  1  result_o valid.
REQ-012 SHALL have busy_o  output  1  operation in flight; the EX stage uses it as a stall request.

Function
REQ-013 SHALL implement states IDLE, BYZERO, ON and END, with a cycle counter of clog2(W)+1 bits.
REQ-014 In IDLE with start_i=1 and annul_i=0, operands and signed_i/mode_i SHALL be latched.
- Next state is BYZERO if dividing and opdata2_i=0; otherwise ON with the counter cleared.
REQ-015 For signed operations, the absolute values of the operands SHALL be latched.
- Quotient is negated when the operand signs differ.
- Remainder takes the sign of the dividend.
- Product is negated when the operand signs differ.
REQ-016 ON SHALL perform one restoring-division step per cycle on a (2W+1)-bit working register.
- Leaves ON after exactly W steps to END, with the sign-corrected result registered.
REQ-017 BYZERO SHALL last one cycle and then go to END with result_o=0.
REQ-018 In END, ready_o SHALL be 1 and result_o held stable; the block stays in END until start_i=0, then returns to IDLE.
- ready_o and result_o are 0 in every other state.
REQ-019 Latency SHALL be:
- normal divide: W+2 cycles from the start_i sample to ready_o=1 (34 when W=32);
- divide by zero: 2 cycles.
REQ-020 busy_o SHALL be 1 in BYZERO and ON, and in IDLE in the same cycle that start_i=1 and annul_i=0; it is 0 in END.
REQ-021 annul_i=1 in BYZERO, ON or END SHALL force IDLE on the next edge with ready_o=0; annul_i=1 in IDLE blocks a start.
REQ-022 Operand changes after the start sample SHALL have no effect until the next IDLE start.
REQ-023 The most negative divided by -1 (signed) SHALL yield quotient equal to the most negative value and remainder 0, with no error flag.

Configuration
REQ-024 With macro HILO_DIV_MUL_EN defined, mode_i=1 SHALL run a W-cycle shift-add multiply through ON, with identical latency and handshake.
- Without the macro, mode_i is ignored and every operation is a divide.

Reset
REQ-025 With rst=1 at a clock edge, the block SHALL:
- enter IDLE;
- clear the counter and working registers;
- drive ready_o=0, busy_o=0 and result_o=0 from the next cycle.
- This applies mid-operation too; rst has priority over annul_i and start_i.

Structure
REQ-026 The state encodings, DIV_RESULT_READY/NOT_READY and DIV_START/STOP constants SHALL be in the shared define package.
REQ-027 hilo_div SHALL be a single module with no sub-modules; sign correction is inline.

Verification
REQ-028 Unsigned divide, W=32: 100 / 7 -> ready_o at cycle 34, result_o = {32'd2, 32'd14}.
REQ-029 Signed divide: -7 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
REQ-030 Divide by zero: 5 / 0 -> ready_o at cycle 2, result_o = 0, busy_o low in END.
REQ-031 annul_i pulsed at step 10 of ON -> IDLE next cycle, ready_o never asserted; an immediate new start of 9 / 3 completes with {0, 3}.
REQ-032 start_i held high 5 cycles after ready_o -> ready_o and result_o stable for all 5 cycles; IDLE one cycle after start_i falls.
REQ-033 With HILO_DIV_MUL_EN: unsigned 0xFFFFFFFF * 2 -> {0x00000001, 0xFFFFFFFE}; signed -3 * 4 -> {0xFFFFFFFF, 0xFFFFFFF4}.
